// File: rtl/cmd_controller.sv
// cmd_controller: issues one command to CMD_physical and collects its 48-bit response.
// Define CMD_RESP_CHECK_EN to build the response framing check that drives resp_error.

module cmd_controller #(
    parameter int WATCHDOG_CYCLES = 255
) (
    input  logic        CLK_SD_card,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_argument,
    input  logic        resp_expected,
    input  logic        physical_inactive,
    input  logic        ACK_in,
    input  logic        REQ_in,
    input  logic [47:0] cmd_response,
    input  logic        timeout_error,
    output logic        new_cmd,
    output logic        REQ_out,
    output logic        ACK_out,
    output logic [37:0] cmd_index_arg,
    output logic        cmd_busy,
    output logic        cmd_complete,
    output logic        cmd_timeout,
    output logic        resp_error,
    output logic [5:0]  response_index,
    output logic [31:0] response_arg
);

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_WAIT_PHY  = 6'b000010,
        ST_LAUNCH    = 6'b000100,
        ST_WAIT_RESP = 6'b001000,
        ST_ACK_RESP  = 6'b010000,
        ST_DONE      = 6'b100000
    } state_e;

    // Last watchdog value seen in WAIT_RESP before the forced timeout.
    localparam logic [7:0] WD_LAST = 8'(WATCHDOG_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        rexp_q, rexp_d;
    logic        tmo_flag_q, tmo_flag_d;
    logic [7:0]  wd_q, wd_d;
    logic [5:0]  rsp_idx_q, rsp_idx_d;
    logic [31:0] rsp_arg_q, rsp_arg_d;
    logic        new_cmd_q, new_cmd_d;
    logic        req_out_q, req_out_d;
    logic        ack_out_q, ack_out_d;
    logic        busy_q, busy_d;
    logic        complete_q, complete_d;
    logic        timeout_q, timeout_d;
    logic        wd_expired_s;
    logic        unused_s;

`ifdef CMD_RESP_CHECK_EN
    logic        rerr_flag_q, rerr_flag_d;
    logic        resp_error_q, resp_error_d;

    // Framing: two zero start bits, a one end bit, and an echoed command index.
    function automatic logic frame_bad(input logic [47:0] rsp, input logic [5:0] idx);
        frame_bad = rsp[47] | rsp[46] | ~rsp[0] | (rsp[45:40] != idx);
    endfunction
`endif

    assign wd_expired_s = (wd_q == WD_LAST);
    assign unused_s     = ^{cmd_response[47:46], cmd_response[7:0]};

    // State register.
    always_ff @(posedge CLK_SD_card) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; response beats physical timeout, which beats the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d = physical_inactive ? ST_LAUNCH : ST_WAIT_PHY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_PHY: begin
                if (physical_inactive) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_WAIT_PHY;
                end
            end
            ST_LAUNCH: begin
                if (ACK_in) begin
                    state_d = ST_WAIT_RESP;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_WAIT_RESP: begin
                if (REQ_in) begin
                    state_d = ST_ACK_RESP;
                end else if (timeout_error || wd_expired_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_ACK_RESP: begin
                if (!REQ_in) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACK_RESP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values and registered outputs, decoded from the next state.
    always_comb begin
        idx_d      = idx_q;
        arg_d      = arg_q;
        rexp_d     = rexp_q;
        tmo_flag_d = tmo_flag_q;
        wd_d       = wd_q;
        rsp_idx_d  = rsp_idx_q;
        rsp_arg_d  = rsp_arg_q;
`ifdef CMD_RESP_CHECK_EN
        rerr_flag_d = rerr_flag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    idx_d      = cmd_index;
                    arg_d      = cmd_argument;
                    rexp_d     = resp_expected;
                    tmo_flag_d = 1'b0;
`ifdef CMD_RESP_CHECK_EN
                    rerr_flag_d = 1'b0;
`endif
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_LAUNCH: wd_d = 8'd0;
            ST_WAIT_RESP: begin
                wd_d = wd_q + 8'd1;
                if (REQ_in) begin
                    rsp_idx_d = cmd_response[45:40];
                    rsp_arg_d = cmd_response[39:8];
`ifdef CMD_RESP_CHECK_EN
                    rerr_flag_d = frame_bad(cmd_response, idx_q);
`endif
                end else if (timeout_error) begin
                    tmo_flag_d = rexp_q;
                end else if (wd_expired_s) begin
                    tmo_flag_d = 1'b1;
                end else begin
                    tmo_flag_d = tmo_flag_q;
                end
            end
            default: wd_d = wd_q;
        endcase

        new_cmd_d  = (state_d == ST_LAUNCH);
        req_out_d  = (state_d == ST_LAUNCH);
        ack_out_d  = (state_d == ST_ACK_RESP);
        busy_d     = (state_d != ST_IDLE);
        complete_d = (state_d == ST_DONE);
        timeout_d  = complete_d & tmo_flag_d;
`ifdef CMD_RESP_CHECK_EN
        resp_error_d = complete_d & rerr_flag_d;
`endif
    end

    // Latched command, captured response, watchdog and output registers.
    always_ff @(posedge CLK_SD_card) begin
        if (reset) begin
            idx_q      <= 6'd0;
            arg_q      <= 32'd0;
            rexp_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            wd_q       <= 8'd0;
            rsp_idx_q  <= 6'd0;
            rsp_arg_q  <= 32'd0;
            new_cmd_q  <= 1'b0;
            req_out_q  <= 1'b0;
            ack_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef CMD_RESP_CHECK_EN
            rerr_flag_q  <= 1'b0;
            resp_error_q <= 1'b0;
`endif
        end else begin
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            rexp_q     <= rexp_d;
            tmo_flag_q <= tmo_flag_d;
            wd_q       <= wd_d;
            rsp_idx_q  <= rsp_idx_d;
            rsp_arg_q  <= rsp_arg_d;
            new_cmd_q  <= new_cmd_d;
            req_out_q  <= req_out_d;
            ack_out_q  <= ack_out_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            timeout_q  <= timeout_d;
`ifdef CMD_RESP_CHECK_EN
            rerr_flag_q  <= rerr_flag_d;
            resp_error_q <= resp_error_d;
`endif
        end
    end

    assign new_cmd        = new_cmd_q;
    assign REQ_out        = req_out_q;
    assign ACK_out        = ack_out_q;
    assign cmd_index_arg  = {idx_q, arg_q};
    assign cmd_busy       = busy_q;
    assign cmd_complete   = complete_q;
    assign cmd_timeout    = timeout_q;
    assign response_index = rsp_idx_q;
    assign response_arg   = rsp_arg_q;
`ifdef CMD_RESP_CHECK_EN
    assign resp_error     = resp_error_q;
`else
    assign resp_error     = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_controller.sv
// Bench for cmd_controller: plays the physical layer from a per-command timeline and
// checks every output each cycle against expectations derived from that timeline.

module tb_cmd_controller;

    localparam int WD = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic        resp_expected;
    logic        physical_inactive;
    logic        ACK_in;
    logic        REQ_in;
    logic [47:0] cmd_response;
    logic        timeout_error;
    logic        new_cmd;
    logic        REQ_out;
    logic        ACK_out;
    logic [37:0] cmd_index_arg;
    logic        cmd_busy;
    logic        cmd_complete;
    logic        cmd_timeout;
    logic        resp_error;
    logic [5:0]  response_index;
    logic [31:0] response_arg;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [5:0]  m_ri = 6'd0;
    logic [31:0] m_ra = 32'd0;

    cmd_controller #(.WATCHDOG_CYCLES(WD)) dut (
        .CLK_SD_card       (clk),
        .reset             (reset),
        .cmd_start         (cmd_start),
        .cmd_index         (cmd_index),
        .cmd_argument      (cmd_argument),
        .resp_expected     (resp_expected),
        .physical_inactive (physical_inactive),
        .ACK_in            (ACK_in),
        .REQ_in            (REQ_in),
        .cmd_response      (cmd_response),
        .timeout_error     (timeout_error),
        .new_cmd           (new_cmd),
        .REQ_out           (REQ_out),
        .ACK_out           (ACK_out),
        .cmd_index_arg     (cmd_index_arg),
        .cmd_busy          (cmd_busy),
        .cmd_complete      (cmd_complete),
        .cmd_timeout       (cmd_timeout),
        .resp_error        (resp_error),
        .response_index    (response_index),
        .response_arg      (response_arg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input int cyc);
        chk("rst_new_cmd", cyc, new_cmd, 0);
        chk("rst_req_out", cyc, REQ_out, 0);
        chk("rst_ack_out", cyc, ACK_out, 0);
        chk("rst_idx_arg", cyc, cmd_index_arg, 0);
        chk("rst_busy", cyc, cmd_busy, 0);
        chk("rst_complete", cyc, cmd_complete, 0);
        chk("rst_timeout", cyc, cmd_timeout, 0);
        chk("rst_resp_err", cyc, resp_error, 0);
        chk("rst_rsp_idx", cyc, response_index, 0);
        chk("rst_rsp_arg", cyc, response_arg, 0);
    endtask

    // mode 0: response, 1: physical timeout, 2: watchdog. Edge e=0 samples cmd_start.
    // b: cycles the phy stays busy; d: ACK delay after new_cmd; r: event delay in WAIT_RESP;
    // h: REQ hold after capture; rst_at >= 0 asserts reset after that edge.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic rexp,
                           input int b, input int d, input int mode, input int r, input int h,
                           input logic [47:0] rsp, input bit extra, input bit collide,
                           input int rst_at);
        int lch, w, m, dn;
        logic exp_tmo, exp_rerr;
        logic [5:0]  e_ri;
        logic [31:0] e_ra;
        lch = b;
        w   = lch + d + 1;
        m   = w + r + 1;
        if (mode == 0)      dn = m + h;
        else if (mode == 1) dn = w + r + 1;
        else                dn = w + WD;
        exp_tmo  = (mode == 2) || (mode == 1 && rexp);
        exp_rerr = 1'b0;
`ifdef CMD_RESP_CHECK_EN
        if (mode == 0) exp_rerr = rsp[47] | rsp[46] | ~rsp[0] | (rsp[45:40] != idx);
`endif
        cmd_start = 1'b1; cmd_index = idx; cmd_argument = arg; resp_expected = rexp;
        physical_inactive = (b == 0); ACK_in = 1'b0; REQ_in = 1'b0; timeout_error = 1'b0;
        for (int e = 0; e <= dn + 1; e++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && e == rst_at + 1) begin
                chk_all_zero(e);
                reset = 1'b0; cmd_start = 1'b0; REQ_in = 1'b0; ACK_in = 1'b0; timeout_error = 1'b0;
                m_ri = 6'd0; m_ra = 32'd0;
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("post_rst_complete", e, cmd_complete, 0);
                    chk("post_rst_busy", e, cmd_busy, 0);
                end
                return;
            end
            e_ri = (mode == 0 && e >= m) ? rsp[45:40] : m_ri;
            e_ra = (mode == 0 && e >= m) ? rsp[39:8]  : m_ra;
            chk("idx_arg", e, cmd_index_arg, {idx, arg});
            chk("busy", e, cmd_busy, e <= dn);
            chk("new_cmd", e, new_cmd, (e >= lch && e < w));
            chk("req_out", e, REQ_out, (e >= lch && e < w));
            chk("ack_out", e, ACK_out, (mode == 0 && e >= m && e < dn));
            chk("complete", e, cmd_complete, e == dn);
            chk("timeout", e, cmd_timeout, (e == dn) && exp_tmo);
            chk("resp_error", e, resp_error, (e == dn) && exp_rerr);
            chk("rsp_idx", e, response_index, e_ri);
            chk("rsp_arg", e, response_arg, e_ra);
            // Inputs seen at edge e+1.
            cmd_start = extra && (e == 0);
            if (extra && e == 0) begin
                cmd_index = ~idx; cmd_argument = ~arg; resp_expected = ~rexp;
            end
            physical_inactive = (e >= b - 1);
            ACK_in        = (e == lch + d);
            REQ_in        = (mode == 0) && (e >= w + r) && (e < m + h - 1);
            timeout_error = (mode == 1 || collide) && (e == w + r);
            cmd_response  = REQ_in ? rsp : {16'($urandom), $urandom};
            reset         = (rst_at >= 0) && (e == rst_at);
        end
        if (mode == 0) begin
            m_ri = rsp[45:40];
            m_ra = rsp[39:8];
        end
    endtask

    initial begin
        logic [5:0]  ri;
        logic [31:0] ra;
        logic [47:0] rr;
        int          md;
        reset = 1'b1; cmd_start = 1'b0; cmd_index = 6'd0; cmd_argument = 32'd0;
        resp_expected = 1'b0; physical_inactive = 1'b1; ACK_in = 1'b0; REQ_in = 1'b0;
        cmd_response = 48'd0; timeout_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero(0);
        reset = 1'b0;

        // Nominal command with the reference response.
        run_cmd(6'h11, 32'h0000_0200, 1'b1, 0, 1, 0, 2, 2, 48'h11_DEADBEEF_01, 1'b0, 1'b0, -1);
        // Physical timeout with and without an expected response.
        run_cmd(6'h08, 32'h0000_01AA, 1'b1, 0, 1, 1, 3, 1, 48'h0, 1'b0, 1'b0, -1);
        run_cmd(6'h00, 32'h0000_0000, 1'b0, 0, 1, 1, 2, 1, 48'h0, 1'b0, 1'b0, -1);
        // Busy physical layer, plus an ignored second cmd_start.
        run_cmd(6'h02, 32'h1234_5678, 1'b1, 4, 1, 0, 1, 2, 48'h02_CAFEF00D_FF, 1'b1, 1'b0, -1);
        // Watchdog with neither REQ nor timeout_error.
        run_cmd(6'h0D, 32'h0001_0000, 1'b0, 0, 0, 2, 0, 1, 48'h0, 1'b0, 1'b0, -1);
        // REQ and timeout_error together: response wins.
        run_cmd(6'h07, 32'hFFFF_0000, 1'b1, 1, 2, 0, 0, 1, 48'h07_00C0FFEE_01, 1'b0, 1'b1, -1);
        // Index mismatch in the response.
        run_cmd(6'h11, 32'h0000_0200, 1'b1, 0, 1, 0, 1, 2, 48'h12_DEADBEEF_01, 1'b0, 1'b0, -1);
        // Reset during ACK_RESP (ACK_out is up after edge m = 4).
        run_cmd(6'h09, 32'hA5A5_5A5A, 1'b1, 0, 1, 0, 1, 3, 48'h09_11223344_01, 1'b0, 1'b0, 4);

        for (int k = 0; k < 12; k++) begin
            ri = 6'($urandom);
            ra = $urandom;
            md = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) rr = {2'b00, ri, $urandom, 7'($urandom), 1'b1};
            else                           rr = {16'($urandom), $urandom};
            run_cmd(ri, ra, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    md, int'($urandom_range(0, 6)), int'($urandom_range(1, 3)), rr,
                    1'($urandom), (md == 0) && ($urandom_range(0, 3) == 0), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmd_controller.md
# cmd_controller

Command-issue sequencer between the host register block and `CMD_physical`. It accepts a command (index, argument, response type) and waits for the physical layer to go idle. It then launches the command over the new_cmd/REQ/ACK handshake, collects the 48-bit response over the reverse REQ/ACK handshake, and reports completion, timeout or response error to the host side. Everything runs in the SD card clock domain.

## Interface
Parameters:
- WATCHDOG_CYCLES, 255: maximum cycles spent in WAIT_RESP before the controller forces a timeout; 8-bit counter.

Ports:
- CLK_SD_card  in  1  SD card clock. All logic is on the posedge.
- reset  in  1  Synchronous, active-high reset.
- cmd_start  in  1  One-cycle host request to issue a command.
- cmd_index  in  6  Command index. Latched when cmd_start is accepted.
- cmd_argument  in  32  Command argument. Latched when cmd_start is accepted.
- resp_expected  in  1  1 = command has a response; 0 = no response (for example CMD0). Latched when cmd_start is accepted.
- physical_inactive  in  1  From the physical layer's physical_inactive.
- ACK_in  in  1  From the physical layer's ACK_out (command accepted).
- REQ_in  in  1  From the physical layer's REQ_out (response ready).
- cmd_response  in  48  From the physical layer's cmd_response.
- timeout_error  in  1  From the physical layer's timeout_error.
- new_cmd  out  1  To the physical layer's new_cmd.
- REQ_out  out  1  To the physical layer's REQ_in.
- ACK_out  out  1  To the physical layer's ACK_in.
- cmd_index_arg  out  38  To the physical layer. Bits [37:32] carry the latched index; bits [31:0] carry the latched argument.
- cmd_busy  out  1  High in every state except IDLE.
- cmd_complete  out  1  One-cycle pulse in DONE.
- cmd_timeout  out  1  One-cycle pulse, together with cmd_complete, on a timeout.
- resp_error  out  1  One-cycle pulse, together with cmd_complete (see Configuration).
- response_index  out  6  Captured cmd_response[45:40]. Held until the next capture.
- response_arg  out  32  Captured cmd_response[39:8]. Held until the next capture.

## Operation
- The state register is one-hot: IDLE, WAIT_PHY, LAUNCH, WAIT_RESP, ACK_RESP, DONE.
- Every output is registered. Reset clears every output and all latches to 0 and sets state to IDLE. Reset mid-operation aborts the command with no cmd_complete pulse.
- IDLE:
  - cmd_start=1: latch the inputs and clear the flags.
  - Go to LAUNCH if physical_inactive=1, otherwise go to WAIT_PHY.
  - cmd_start is ignored in every state other than IDLE.
- WAIT_PHY: stay until physical_inactive=1, then go to LAUNCH.
- LAUNCH:
  - new_cmd=1, REQ_out=1.
  - On ACK_in=1, deassert both and go to WAIT_RESP. The watchdog clears on entry to WAIT_RESP.
- WAIT_RESP: the watchdog counts every cycle. The first matching condition applies:
  1. REQ_in=1: capture response_index and response_arg, set ACK_out=1, go to ACK_RESP.
  2. timeout_error=1: set the timeout flag (when resp_expected=1), go to DONE.
  3. Watchdog reaches WATCHDOG_CYCLES: set the timeout flag (regardless of resp_expected), go to DONE.
- Simultaneous REQ_in and timeout_error resolves to the response (condition 1).
- ACK_RESP: hold ACK_out=1 until REQ_in=0, then drop ACK_out and go to DONE.
- DONE:
  - One cycle with cmd_complete=1. cmd_timeout and resp_error carry their flags.
  - Then return to IDLE.
  - A cmd_start in the cycle after DONE is accepted normally.

## Timing
- cmd_start at edge N, with the physical layer idle:
  - new_cmd is high after edge N+1.
  - The physical layer ACKs combinationally after edge N+2.
  - The controller reaches WAIT_RESP at edge N+3, and new_cmd/REQ_out are low from N+3.
- Response:
  - REQ_in sampled high at edge M: capture and ACK_out=1 after M.
  - The physical layer drops REQ at M+1.
  - DONE at M+2, IDLE at M+3.
- Physical timeout: timeout_error sampled at edge T gives DONE after T and a cmd_complete/cmd_timeout pulse in the cycle T..T+1.
- Command to completion is no more than 3 + WATCHDOG_CYCLES + 3 cycles.

## Configuration
- `CMD_RESP_CHECK_EN` defined: at capture, check the response framing.
  - resp_error is set if cmd_response[47]!=0, cmd_response[46]!=0, cmd_response[0]!=1, or response_index!=latched cmd_index.
  - resp_error is pulsed in DONE.
- Not defined: resp_error is a constant 0 and no check logic is built.

## Test plan
- Idle physical layer, cmd_start with index 6'h11 and argument 32'h0000_0200: new_cmd/REQ_out high for exactly 2 cycles. A response of 48'h11_DEADBEEF_01 gives response_index=6'h11, response_arg=32'hDEADBEEF, and one cmd_complete pulse with cmd_timeout=0.
- resp_expected=1 and timeout_error pulses in WAIT_RESP: cmd_complete=1 and cmd_timeout=1 in the same cycle, response registers unchanged.
- resp_expected=0 (CMD0) and the physical layer times out: cmd_complete=1 with cmd_timeout=0.
- physical_inactive=0 when cmd_start arrives: stays in WAIT_PHY and new_cmd stays 0. new_cmd rises one cycle after physical_inactive=1. A second cmd_start while busy is ignored.
- No REQ and no timeout for 255 cycles: forced cmd_timeout. Reset asserted during ACK_RESP: all outputs 0 and no cmd_complete pulse.
- With `CMD_RESP_CHECK_EN`: a response whose index is 6'h12 for an issued index of 6'h11 pulses resp_error=1. Without the macro, resp_error stays 0.
